tl_ul_channel_buffer: RTL
=========================

// Module: tl_ul_channel_buffer
// PURPOSE
//  Parametrised TL-UL A/D channel buffer between a master port and a slave port;
//  successor to the fixed zero-depth wire-through node. Each direction has an
//  independent FIFO of configurable depth, plus optional flow-through and pipe modes.
//  Depth 0 on a channel degenerates to pure wires for that channel.
// PARAMETERS
//  ADDR_W   32  A address width
//  DATA_W   32  data width; mask width is DATA_W/8
//  SRC_W    2   source id width
//  SINK_W   1   sink id width
//  A_DEPTH  2   A FIFO entries (0 = wire-through; otherwise any value >=1)
//  D_DEPTH  2   D FIFO entries (0 = wire-through; otherwise any value >=1)
//  FLOW     0   1: empty FIFO forwards input to output in the same cycle
//  PIPE     0   1: a full FIFO accepts a push in a cycle where it also pops
// PORTS
//  clock         in   1   sole clock, rising edge
//  reset_n       in   1   asynchronous active-low reset
//  a_in_valid    in   1   master A valid
//  a_in_ready    out  1   master A ready
//  a_in_bits     in   AW  {opcode[2:0],param[2:0],size[2:0],source,address,mask,data,corrupt}
//  a_out_valid   out  1   slave A valid
//  a_out_ready   in   1   slave A ready
//  a_out_bits    out  AW  same packing as a_in_bits
//  d_in_valid    in   1   slave D valid
//  d_in_ready    out  1   slave D ready
//  d_in_bits     in   DW  {opcode[2:0],param[1:0],size[2:0],source,sink,denied,data,corrupt}
//  d_out_valid   out  1   master D valid
//  d_out_ready   in   1   master D ready
//  d_out_bits    out  DW  same packing as d_in_bits
//  a_count       out  CA  A occupancy, CA = clog2(A_DEPTH+1) (1 bit when depth 0, tied 0)
//  d_count       out  CD  D occupancy, same width rule
// BEHAVIOUR
//  - Reset (async assert, sync-to-clock deassert internal): count=0, rd/wr ptr=0,
//    *_out_valid=0, *_in_ready=1; stored payloads are not reset (don't-care).
//  - Per channel: push = in_valid & in_ready; pop = out_valid & out_ready.
//    No combinational path from in_valid to in_ready.
//  - in_ready = (count<DEPTH) | (PIPE & out_ready & count!=0).
//  - out_valid = (count!=0) | (FLOW & in_valid); out_bits = head entry, or
//    in_bits when FLOW and count==0 (bypass; no write if popped same cycle).
//  - Latency: FLOW=0 -> 1 cycle in-to-out minimum; FLOW=1 -> 0 cycles when empty.
//  - Count: +1 on push-only, -1 on pop-only, unchanged on push&pop (incl. bypass).
//  - Pointers advance modulo DEPTH (non-power-of-2 wraps DEPTH-1 -> 0 explicitly).
//  - Ordering strictly FIFO; payload bits never altered; A and D fully independent.
//  - Full: count==DEPTH, in_ready=0 unless PIPE rule applies. Empty: out_valid=0
//    unless FLOW bypass. Depth 1 with PIPE=1 sustains 1 beat/cycle.
//  - DEPTH==0: in_ready=out_ready, out_valid=in_valid, out_bits=in_bits, count=0;
//    FLOW/PIPE ignored; reset has no effect on that channel.
//  - Reset asserted mid-burst: all held beats discarded immediately, outputs go
//    to reset values asynchronously; no partial beat is emitted afterwards.
//  - out_valid, once high, stays high with stable bits until popped (TL rule).
// TESTING
//  1 Reset, A_DEPTH=2: push 0x1000/0x2000 with a_out_ready=0 -> a_count=2,
//    a_in_ready=0, 3rd beat held; release ready -> 0x1000 then 0x2000 out.
//  2 A_DEPTH=3, 10 beats, a_out_ready toggling 1010..  -> order preserved across
//    pointer wrap 2->0, a_count never >3.
//  3 FLOW=1, empty, d_in_valid with data 0xDEADBEEF, d_out_ready=1 -> d_out_valid
//    same cycle, d_count stays 0; FLOW=0 -> appears next cycle.
//  4 PIPE=1, depth 1 full, both readys 1, continuous stream -> 1 beat/cycle, no
//    bubble; PIPE=0 -> every other cycle.
//  5 Fill both channels, drop reset_n mid-cycle -> valids 0, readys 1, counts 0
//    before next edge; no stale beat after release.
//  6 A_DEPTH=D_DEPTH=0 -> every output equals its input combinationally, counts 0.

Source files
------------

// File: rtl/tl_ul_channel_buffer.sv
// TL-UL A/D channel buffer: an independent FIFO per direction with optional
// flow-through and pipe modes; a depth of 0 turns that channel into plain wires.

module tl_ul_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned FLOW  = 0,
  parameter int unsigned PIPE  = 0,
  parameter int unsigned CW    = 2
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bits,
  output logic [CW-1:0]    count
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty, full, push, pop, bypass, wr_en, rd_en;

  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CW'(DEPTH));
    in_ready  = !full || ((PIPE != 0) && out_ready && !empty);
    out_valid = !empty || ((FLOW != 0) && in_valid);
    out_bits  = ((FLOW != 0) && empty) ? in_bits : mem_q[rd_ptr_q];
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    // A bypassed beat leaves the buffer untouched: no write, no read.
    bypass    = (FLOW != 0) && empty && pop;
    wr_en     = push && !bypass;
    rd_en     = pop && !bypass;

    wr_ptr_d = wr_ptr_q;
    if (wr_en) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    rd_ptr_d = rd_ptr_q;
    if (rd_en) rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);

    count_d = count_q;
    if (wr_en && !rd_en)      count_d = count_q + CW'(1);
    else if (rd_en && !wr_en) count_d = count_q - CW'(1);
    count = count_q;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_bits;
  end
endmodule

module tl_ul_channel_buffer #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SRC_W   = 2,
  parameter int unsigned SINK_W  = 1,
  parameter int unsigned A_DEPTH = 2,
  parameter int unsigned D_DEPTH = 2,
  parameter int unsigned FLOW    = 0,
  parameter int unsigned PIPE    = 0,
  localparam int unsigned AW = 9 + SRC_W + ADDR_W + DATA_W / 8 + DATA_W + 1,
  localparam int unsigned DW = 8 + SRC_W + SINK_W + 1 + DATA_W + 1,
  localparam int unsigned CA = (A_DEPTH == 0) ? 1 : $clog2(A_DEPTH + 1),
  localparam int unsigned CD = (D_DEPTH == 0) ? 1 : $clog2(D_DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          a_in_valid,
  output logic          a_in_ready,
  input  logic [AW-1:0] a_in_bits,
  output logic          a_out_valid,
  input  logic          a_out_ready,
  output logic [AW-1:0] a_out_bits,
  input  logic          d_in_valid,
  output logic          d_in_ready,
  input  logic [DW-1:0] d_in_bits,
  output logic          d_out_valid,
  input  logic          d_out_ready,
  output logic [DW-1:0] d_out_bits,
  output logic [CA-1:0] a_count,
  output logic [CD-1:0] d_count
);
  // Reset asserts asynchronously but releases two clock edges later.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_int_n;
  logic       unused_rst;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= rst_sync_d;
  end

  assign rst_int_n  = rst_sync_q[1];
  assign unused_rst = rst_int_n;

  if (A_DEPTH == 0) begin : g_a_wire
    assign a_in_ready  = a_out_ready;
    assign a_out_valid = a_in_valid;
    assign a_out_bits  = a_in_bits;
    assign a_count     = '0;
  end else begin : g_a_fifo
    tl_ul_fifo #(.WIDTH(AW), .DEPTH(A_DEPTH), .FLOW(FLOW), .PIPE(PIPE), .CW(CA)) u_a_fifo (
      .clock(clock), .rst_n(rst_int_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_bits(a_in_bits),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_bits(a_out_bits),
      .count(a_count)
    );
  end

  if (D_DEPTH == 0) begin : g_d_wire
    assign d_in_ready  = d_out_ready;
    assign d_out_valid = d_in_valid;
    assign d_out_bits  = d_in_bits;
    assign d_count     = '0;
  end else begin : g_d_fifo
    tl_ul_fifo #(.WIDTH(DW), .DEPTH(D_DEPTH), .FLOW(FLOW), .PIPE(PIPE), .CW(CD)) u_d_fifo (
      .clock(clock), .rst_n(rst_int_n),
      .in_valid(d_in_valid), .in_ready(d_in_ready), .in_bits(d_in_bits),
      .out_valid(d_out_valid), .out_ready(d_out_ready), .out_bits(d_out_bits),
      .count(d_count)
    );
  end
endmodule
